// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t  : arbiter FSM states (IDLE, I_BUSY, D_BUSY)
//   grant_t  : which requester owns the shared memory (GNT_I, GNT_D)
//   ERR_*    : bit positions inside the sticky err vector
//   rr_pick  : round-robin choice between the two requesters
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_I_BUSY = 2'd1,
      ST_D_BUSY = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   localparam int unsigned ERR_W        = 2;
   localparam int unsigned ERR_TIMEOUT  = 0;
   localparam int unsigned ERR_CONFLICT = 1;

   // On a tie the port that was not served last wins; result only meaningful
   // when at least one request is present.
   function automatic grant_t rr_pick(input logic i_req, input logic d_req,
                                      input grant_t last);
      if (i_req && d_req) begin
         return (last == GNT_I) ? GNT_D : GNT_I;
      end else if (d_req) begin
         return GNT_D;
      end else begin
         return GNT_I;
      end
   endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the instruction port, the data port and the shared
// memory port around the arbiter.
//   i_*    : instruction requester (read only)
//   d_*    : data requester (read or write, byte enables)
//   pmem_* : shared physical memory
// Modport slave is the arbiter's view (it serves both requesters and drives
// the memory); modport master is the environment's view.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_byte_enable;
   logic [DATA_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [DATA_W-1:0] pmem_wdata;
   logic [BE_W-1:0]   pmem_byte_enable;
   logic [DATA_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_address,
      output i_rdata, i_resp,
      input  d_read, d_write, d_address, d_wdata, d_byte_enable,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output i_read, i_address,
      input  i_rdata, i_resp,
      output d_read, d_write, d_address, d_wdata, d_byte_enable,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
      output pmem_rdata, pmem_resp
   );

endinterface : mem_arb_if

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts busy cycles that pass without a memory response.
//   clk, rst : clock, synchronous active-low reset
//   clear    : restart the count (new transaction granted)
//   enable   : a busy cycle without pmem_resp is ending
//   hit      : this cycle brings the count to TIMEOUT (or it is already there)
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic hit
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // Saturating counter; the transaction keeps waiting after saturation.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         count <= '0;
      end else if (enable && (count != CNT_W'(TIMEOUT))) begin
         count <= count + CNT_W'(1);
      end
   end

   // Flag the edge on which the count arrives at TIMEOUT so the sticky error
   // bit becomes visible together with the saturated count.
   assign hit = enable && (count >= CNT_W'(TIMEOUT - 1));

endmodule : mem_arb_watchdog

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an
// instruction requester and a data requester.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : mem_arb_if.slave (i_*, d_*, pmem_* signals)
//   err  : sticky flags, bit ERR_TIMEOUT = watchdog, bit ERR_CONFLICT =
//          data port asked for read and write at once
// The memory request is captured at grant and replayed from registers for the
// whole transaction; only the completion pulse and read data are passed
// combinationally from the memory back to the granted requester.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   mem_arb_if.slave         bus,
   output logic [ERR_W-1:0] err
);
   localparam int unsigned BE_W = DATA_W / 8;

   state_t            state;
   state_t            state_next;
   grant_t            grant;
   grant_t            last_grant;
   logic              load;
   logic              done;
   logic              busy;
   logic              i_req;
   logic              d_req;
   logic              wd_hit;
   logic              i_resp_c;
   logic              d_resp_c;

   logic              rd_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;
   assign busy  = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, grant decision and completion detect.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      grant      = GNT_I;
      done       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (i_req || d_req) begin
               load       = 1'b1;
               grant      = rr_pick(i_req, d_req, last_grant);
               state_next = (grant == GNT_D) ? ST_D_BUSY : ST_I_BUSY;
            end
         end
         ST_I_BUSY, ST_D_BUSY: begin
            if (bus.pmem_resp) begin
               done       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request capture, strobe control, round-robin history and sticky errors.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant <= GNT_D;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         err        <= '0;
      end else begin
         if (load) begin
            if (grant == GNT_D) begin
               addr_q  <= bus.d_address;
               wdata_q <= bus.d_wdata;
               be_q    <= bus.d_byte_enable;
               // Read+write together resolves to a write.
               rd_q    <= ~bus.d_write;
               wr_q    <= bus.d_write;
               if (bus.d_read && bus.d_write) begin
                  err[ERR_CONFLICT] <= 1'b1;
               end
            end else begin
               addr_q  <= bus.i_address;
               wdata_q <= '0;
               be_q    <= '1;
               rd_q    <= 1'b1;
               wr_q    <= 1'b0;
            end
         end else if (done) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            last_grant <= (state == ST_D_BUSY) ? GNT_D : GNT_I;
         end
         if (wd_hit) begin
            err[ERR_TIMEOUT] <= 1'b1;
         end
      end
   end

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (load),
      .enable (busy && !bus.pmem_resp),
      .hit    (wd_hit)
   );

   // Completion routing; gated by rst so nothing leaks out while in reset.
   assign i_resp_c = rst && (state == ST_I_BUSY) && bus.pmem_resp;
   assign d_resp_c = rst && (state == ST_D_BUSY) && bus.pmem_resp;

   assign bus.i_resp  = i_resp_c;
   assign bus.d_resp  = d_resp_c;
   assign bus.i_rdata = i_resp_c ? bus.pmem_rdata : '0;
   assign bus.d_rdata = d_resp_c ? bus.pmem_rdata : '0;

   assign bus.pmem_read        = rd_q;
   assign bus.pmem_write       = wr_q;
   assign bus.pmem_address     = addr_q;
   assign bus.pmem_wdata       = wdata_q;
   assign bus.pmem_byte_enable = be_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level model of the arbiter rules.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [ERR_W-1:0] err;

   int checks   = 0;
   int failures = 0;

   mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .err (err)
   );

   always #5 clk = ~clk;

   // Reference model: which port owns memory, what it asked for, history.
   int                m_port;   // -1 none, 0 instruction, 1 data
   int                m_last;   // port served most recently
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [BE_W-1:0]   m_be;
   logic              m_wr;
   int unsigned       m_wait;   // busy cycles elapsed without a response
   logic [1:0]        m_err;
   bit                m_fresh;  // nothing granted since reset

   // Inputs as seen during the current cycle, applied at the next edge.
   logic              s_rst, s_i_read, s_d_read, s_d_write, s_resp;
   logic [ADDR_W-1:0] s_i_addr, s_d_addr;
   logic [DATA_W-1:0] s_d_wdata;
   logic [BE_W-1:0]   s_d_be;

   bit i_seen, d_seen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_port  = -1;
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      m_wr    = 1'b0;
      m_wait  = 0;
      m_err   = 2'b00;
      m_fresh = 1'b1;
   endtask

   // Compare outputs at the falling edge and record this cycle's inputs.
   task automatic sample();
      bit   busy;
      logic exp_i, exp_d;
      @(negedge clk);
      busy  = (m_port >= 0);
      exp_i = rst && (m_port == 0) && bus.pmem_resp;
      exp_d = rst && (m_port == 1) && bus.pmem_resp;
      chk("pmem_read",  64'(bus.pmem_read),  64'(busy && !m_wr));
      chk("pmem_write", 64'(bus.pmem_write), 64'(busy && m_wr));
      if (busy || m_fresh) begin
         chk("pmem_address",     64'(bus.pmem_address),     64'(m_addr));
         chk("pmem_wdata",       64'(bus.pmem_wdata),       64'(m_wdata));
         chk("pmem_byte_enable", 64'(bus.pmem_byte_enable), 64'(m_be));
      end
      chk("i_resp", 64'(bus.i_resp), 64'(exp_i));
      chk("d_resp", 64'(bus.d_resp), 64'(exp_d));
      if (exp_i) chk("i_rdata", 64'(bus.i_rdata), 64'(bus.pmem_rdata));
      else if (m_fresh) chk("i_rdata_zero", 64'(bus.i_rdata), 64'(0));
      if (exp_d) chk("d_rdata", 64'(bus.d_rdata), 64'(bus.pmem_rdata));
      else if (m_fresh) chk("d_rdata_zero", 64'(bus.d_rdata), 64'(0));
      chk("err", 64'(err), 64'(m_err));
      i_seen    = bus.i_resp;
      d_seen    = bus.d_resp;
      s_rst     = rst;
      s_i_read  = bus.i_read;
      s_i_addr  = bus.i_address;
      s_d_read  = bus.d_read;
      s_d_write = bus.d_write;
      s_d_addr  = bus.d_address;
      s_d_wdata = bus.d_wdata;
      s_d_be    = bus.d_byte_enable;
      s_resp    = bus.pmem_resp;
   endtask

   // Advance the model across the rising edge, then leave 1ns for drives.
   task automatic adv();
      int pick;
      @(posedge clk);
      if (!s_rst) begin
         model_reset();
      end else if (m_port < 0) begin
         pick = -1;
         if (s_i_read && (s_d_read || s_d_write)) pick = (m_last == 0) ? 1 : 0;
         else if (s_i_read) pick = 0;
         else if (s_d_read || s_d_write) pick = 1;
         if (pick == 0) begin
            m_addr  = s_i_addr;
            m_wdata = '0;
            m_be    = '1;
            m_wr    = 1'b0;
         end else if (pick == 1) begin
            m_addr  = s_d_addr;
            m_wdata = s_d_wdata;
            m_be    = s_d_be;
            m_wr    = s_d_write;
            if (s_d_read && s_d_write) m_err[1] = 1'b1;
         end
         if (pick >= 0) begin
            m_port  = pick;
            m_wait  = 0;
            m_fresh = 1'b0;
         end
      end else if (s_resp) begin
         m_last = m_port;
         m_port = -1;
      end else begin
         m_wait++;
         if (m_wait >= TIMEOUT) m_err[0] = 1'b1;
      end
      #1;
   endtask

   task automatic new_d_kind();
      int unsigned k;
      k = $urandom_range(0, 7);
      bus.d_read  = (k < 4) || (k == 7);
      bus.d_write = (k >= 4);
   endtask

   task automatic drive_random();
      rst = ($urandom_range(0, 299) != 0);
      if (bus.i_read) begin
         if (i_seen) bus.i_read = 1'($urandom_range(0, 1));
      end else begin
         bus.i_read = ($urandom_range(0, 3) == 0);
      end
      if (bus.d_read || bus.d_write) begin
         if (d_seen) begin
            if ($urandom_range(0, 1) == 0) begin
               bus.d_read  = 1'b0;
               bus.d_write = 1'b0;
            end else begin
               new_d_kind();
            end
         end
      end else if ($urandom_range(0, 3) == 0) begin
         new_d_kind();
      end
      // Payloads wander every cycle, including while a grant is in flight.
      bus.i_address     = $urandom;
      bus.d_address     = $urandom;
      bus.d_wdata       = $urandom;
      bus.d_byte_enable = BE_W'($urandom);
      bus.pmem_resp     = ($urandom_range(0, 2) == 0);
      bus.pmem_rdata    = $urandom;
   endtask

   initial begin
      int  n;
      logic exp_d;

      rst                = 1'b0;
      bus.i_read         = 1'b0;
      bus.i_address      = '0;
      bus.d_read         = 1'b0;
      bus.d_write        = 1'b0;
      bus.d_address      = '0;
      bus.d_wdata        = '0;
      bus.d_byte_enable  = '0;
      bus.pmem_rdata     = '0;
      bus.pmem_resp      = 1'b0;
      i_seen             = 1'b0;
      d_seen             = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      sample(); adv();
      rst = 1'b1;

      // Instruction read, response after three waiting cycles.
      bus.i_read = 1'b1; bus.i_address = 32'h60;
      sample(); adv();
      sample();
      chk("t1_pmem_read", 64'(bus.pmem_read), 64'(1));
      chk("t1_address", 64'(bus.pmem_address), 64'h60);
      adv();
      sample(); adv();
      sample(); adv();
      bus.pmem_resp = 1'b1; bus.pmem_rdata = 32'h13;
      sample();
      chk("t1_i_resp", 64'(bus.i_resp), 64'(1));
      chk("t1_i_rdata", 64'(bus.i_rdata), 64'h13);
      adv();
      bus.i_read = 1'b0; bus.pmem_resp = 1'b0;
      sample();
      chk("t1_idle", 64'(bus.pmem_read), 64'(0));
      adv();

      // Data write with partial byte enables.
      bus.d_write = 1'b1; bus.d_address = 32'h100;
      bus.d_wdata = 32'hDEADBEEF; bus.d_byte_enable = 4'h3;
      sample(); adv();
      bus.pmem_resp = 1'b1;
      sample();
      chk("t2_pmem_write", 64'(bus.pmem_write), 64'(1));
      chk("t2_pmem_read", 64'(bus.pmem_read), 64'(0));
      chk("t2_address", 64'(bus.pmem_address), 64'h100);
      chk("t2_wdata", 64'(bus.pmem_wdata), 64'hDEADBEEF);
      chk("t2_be", 64'(bus.pmem_byte_enable), 64'h3);
      chk("t2_d_resp", 64'(bus.d_resp), 64'(1));
      chk("t2_i_resp", 64'(bus.i_resp), 64'(0));
      adv();
      bus.d_write = 1'b0; bus.pmem_resp = 1'b0;

      // Both ports held from reset: strict alternation starting with I.
      rst = 1'b0; bus.i_read = 1'b1; bus.d_read = 1'b1;
      sample(); adv();
      rst = 1'b1; bus.pmem_resp = 1'b1;
      n = 0; exp_d = 1'b0;
      repeat (8) begin
         sample();
         if (bus.i_resp || bus.d_resp) begin
            chk("t3_order", 64'(bus.d_resp), 64'(exp_d));
            exp_d = !exp_d;
            n++;
         end
         chk("t3_overlap", 64'(bus.i_resp && bus.d_resp), 64'(0));
         adv();
      end
      chk("t3_count", 64'(n), 64'(4));
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.pmem_resp = 1'b0;

      // Watchdog: memory silent for ten busy cycles.
      rst = 1'b0;
      sample(); adv();
      rst = 1'b1; bus.i_read = 1'b1;
      sample(); adv();
      for (int k = 1; k <= 10; k++) begin
         sample();
         if (k == 10) chk("t4_err_timeout", 64'(err), 64'h1);
         adv();
      end
      bus.pmem_resp = 1'b1;
      sample();
      chk("t4_i_resp", 64'(bus.i_resp), 64'(1));
      adv();
      bus.i_read = 1'b0; bus.pmem_resp = 1'b0;
      sample();
      chk("t4_err_sticky", 64'(err), 64'h1);
      adv();

      // Read+write conflict, then reset in the middle of the transaction.
      rst = 1'b0;
      sample(); adv();
      rst = 1'b1;
      bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h200;
      sample(); adv();
      sample();
      chk("t5_pmem_write", 64'(bus.pmem_write), 64'(1));
      chk("t5_pmem_read", 64'(bus.pmem_read), 64'(0));
      chk("t5_err_conflict", 64'(err), 64'h2);
      adv();
      rst = 1'b0;
      sample(); adv();
      rst = 1'b1; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.pmem_resp = 1'b1;
      sample();
      chk("t5_rst_write", 64'(bus.pmem_write), 64'(0));
      chk("t5_rst_d_resp", 64'(bus.d_resp), 64'(0));
      chk("t5_rst_err", 64'(err), 64'(0));
      adv();
      bus.pmem_resp = 1'b0;

      // Randomized traffic.
      repeat (3000) begin
         drive_random();
         sample();
         adv();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_arbiter
